// File: rtl/timer_scheduler_if.sv
// APB-style link between the scheduler (master) and the shared timer slave.
interface timer_scheduler_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              m_sel;
  logic              m_enable;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;
  logic              m_slverr;

  modport master (output m_sel, m_enable, m_write, m_addr, m_wdata,
                  input  m_rdata, m_ready, m_slverr);
  modport slave  (input  m_sel, m_enable, m_write, m_addr, m_wdata,
                  output m_rdata, m_ready, m_slverr);
endinterface

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one APB timer among N_REQ requesters:
// program GOAL, start, poll STATUS until COMPLETE (or abort with stop).
module timer_scheduler #(
  parameter int N_REQ      = 2,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int POLL_GAP   = 4,
  parameter int POLL_LIMIT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_goal,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        err,
  output logic                    busy,
  timer_scheduler_if.master       m
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int CW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_GOAL, S_WR_START, S_GAP, S_RD_STAT, S_ABORT, S_DONE, S_ERR
  } state_t;
  // PH_IDLE keeps sel low for one cycle between back-to-back transfers
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

  state_t            state, state_nx;
  phase_t            phase, phase_nx;
  logic [GW-1:0]     grant, grant_nx, ptr, ptr_nx, pick;
  logic [DATA_W-1:0] goal, goal_nx, pick_goal;
  logic [PW-1:0]     polls, polls_nx;
  logic [CW-1:0]     gap, gap_nx;
  logic              found, is_xfer, xfer_ok;
  logic              unused_rdata;

  assign unused_rdata = ^{m.m_rdata[DATA_W-1:4], m.m_rdata[1:0]};

  // lowest offset from ptr wins; loop runs high-to-low so it overwrites last
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = GW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign pick_goal = req_goal[int'(pick)*DATA_W +: DATA_W];
  assign is_xfer   = (state == S_WR_GOAL) || (state == S_WR_START) ||
                     (state == S_RD_STAT) || (state == S_ABORT);
  assign xfer_ok   = is_xfer && (phase == PH_ACCESS) && m.m_ready;

  always_comb begin
    m.m_sel    = 1'b0;
    m.m_enable = 1'b0;
    m.m_write  = 1'b0;
    m.m_addr   = '0;
    m.m_wdata  = '0;
    if (is_xfer && phase != PH_IDLE) begin
      m.m_sel    = 1'b1;
      m.m_enable = (phase == PH_ACCESS);
      case (state)
        S_WR_GOAL:  begin m.m_write = 1'b1; m.m_addr = ADDR_W'(1); m.m_wdata = goal; end
        S_WR_START: begin m.m_write = 1'b1; m.m_wdata = DATA_W'(1); end
        S_ABORT:    begin m.m_write = 1'b1; m.m_wdata = DATA_W'(2); end
        default:    ;
      endcase
    end
  end

  always_comb begin
    done = '0;
    err  = '0;
    if (state == S_DONE) done[grant] = 1'b1;
    if (state == S_ERR)  err[grant]  = 1'b1;
  end

  assign busy = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    grant_nx = grant;
    goal_nx  = goal;
    polls_nx = polls;
    gap_nx   = gap;
    ptr_nx   = ptr;
    if (is_xfer) begin
      case (phase)
        PH_IDLE:  phase_nx = PH_SETUP;
        PH_SETUP: phase_nx = PH_ACCESS;
        default:  ;
      endcase
    end
    unique case (state)
      S_IDLE: if (found) begin
        grant_nx = pick;
        goal_nx  = pick_goal;
        polls_nx = '0;
        if (pick_goal == '0) state_nx = S_DONE;
        else begin
          state_nx = S_WR_GOAL;
          phase_nx = PH_SETUP;
        end
      end
      S_WR_GOAL: if (xfer_ok) begin
        state_nx = m.m_slverr ? S_ERR : S_WR_START;
        phase_nx = PH_IDLE;
      end
      S_WR_START: if (xfer_ok) begin
        state_nx = m.m_slverr ? S_ERR : S_GAP;
        gap_nx   = '0;
      end
      S_GAP: begin
        if (gap == CW'(POLL_GAP - 1)) begin
          state_nx = S_RD_STAT;
          phase_nx = PH_SETUP;
        end else gap_nx = gap + 1'b1;
      end
      S_RD_STAT: if (xfer_ok) begin
        if (m.m_slverr)                     state_nx = S_ERR;
        else if (m.m_rdata[3:2] == 2'd2)    state_nx = S_DONE;
        else if (polls == PW'(POLL_LIMIT - 1)) begin
          state_nx = S_ABORT;
          phase_nx = PH_IDLE;
        end else begin
          polls_nx = polls + 1'b1;
          gap_nx   = '0;
          state_nx = S_GAP;
        end
      end
      S_ABORT: if (xfer_ok) state_nx = S_ERR;
      S_DONE, S_ERR: begin
        state_nx = S_IDLE;
        ptr_nx   = (grant == GW'(N_REQ - 1)) ? '0 : grant + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      phase <= PH_IDLE;
      grant <= '0;
      ptr   <= '0;
      goal  <= '0;
      polls <= '0;
      gap   <= '0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      grant <= grant_nx;
      ptr   <= ptr_nx;
      goal  <= goal_nx;
      polls <= polls_nx;
      gap   <= gap_nx;
    end
  end
endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: behavioural timer slave, job-level expected transfer lists.
module tb_timer_scheduler;
  localparam int N_REQ = 2, DW = 8, AW = 2, GAP = 3, LIM = 4;

  logic                clk = 1'b0, reset = 1'b0;
  logic [N_REQ-1:0]    req = '0;
  logic [N_REQ*DW-1:0] req_goal = '0;
  logic [N_REQ-1:0]    done, err;
  logic                busy;

  timer_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) apb();

  timer_scheduler #(.N_REQ(N_REQ), .DATA_W(DW), .ADDR_W(AW), .POLL_GAP(GAP), .POLL_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .req(req), .req_goal(req_goal),
    .done(done), .err(err), .busy(busy), .m(apb.master));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave knobs: poll number answering COMPLETE (0 = never), transfer index given slverr
  int complete_at = 0, err_at = -1, wmin = 0, wmax = 0;
  int xfer_n = 0, poll_n = 0, wcnt = 0, wtarget = 0;
  logic [10:0] seen[$];
  logic [10:0] setup_cap = '0;
  bit last_done = 0;

  always @(negedge clk) begin
    chk("sel_gap", last_done ? {31'd0, apb.m_sel} : 32'd0, 32'd0);
    chk("one_pulse", {31'd0, $countones({done, err}) <= 1}, 32'd1);
    last_done = 0;
    if (apb.m_sel && !apb.m_enable) begin
      setup_cap = {apb.m_write, apb.m_addr, apb.m_wdata};
      if (apb.m_write && apb.m_addr == 2'd1) begin xfer_n = 0; poll_n = 0; end
      wcnt = 0;
      wtarget = $urandom_range(wmax, wmin);
      apb.m_ready = 1'b0; apb.m_slverr = 1'b0;
    end else if (apb.m_sel && apb.m_enable) begin
      chk("stable", {21'd0, apb.m_write, apb.m_addr, apb.m_wdata}, {21'd0, setup_cap});
      if (wcnt >= wtarget) begin
        apb.m_ready  = 1'b1;
        apb.m_slverr = (xfer_n == err_at);
        if (!apb.m_write) begin
          poll_n++;
          apb.m_rdata = (poll_n == complete_at) ? {4'($urandom), 2'b10, 2'($urandom)}
                                                : {4'($urandom), 2'b01, 2'($urandom)};
          seen.push_back({1'b0, apb.m_addr, 8'h00});
        end else begin
          apb.m_rdata = 8'($urandom);
          seen.push_back(setup_cap);
        end
        xfer_n++;
        last_done = 1;
      end else begin
        apb.m_ready = 1'b0;
        wcnt++;
      end
    end else begin
      apb.m_ready = 1'b0; apb.m_slverr = 1'b0; apb.m_rdata = '0;
    end
  end

  int ptr_m = 0;

  task automatic do_job(input string tag, input logic [1:0] rq, input logic [7:0] g0, input logic [7:0] g1,
                        input int c, input int e, input int wlo, input int whi);
    int g, base, cyc;
    logic [7:0] goal;
    logic [10:0] exp[$];
    bit exp_done;
    complete_at = c; err_at = e; wmin = wlo; wmax = whi;
    g = -1;
    for (int k = 0; k < N_REQ; k++)
      if (g < 0 && rq[(ptr_m + k) % N_REQ]) g = (ptr_m + k) % N_REQ;
    goal = (g == 0) ? g0 : g1;
    exp_done = 1;
    if (goal != 0) begin
      exp.push_back({1'b1, 2'd1, goal});
      exp.push_back({1'b1, 2'd0, 8'h01});
      if (c >= 1 && c <= LIM) for (int i = 0; i < c; i++) exp.push_back({1'b0, 2'd0, 8'h00});
      else begin
        for (int i = 0; i < LIM; i++) exp.push_back({1'b0, 2'd0, 8'h00});
        exp.push_back({1'b1, 2'd0, 8'h02});
        exp_done = 0;
      end
      if (e >= 0 && e < exp.size()) begin
        while (exp.size() > e + 1) void'(exp.pop_back());
        exp_done = 0;
      end
    end
    base = seen.size();
    req_goal = {g1, g0};
    req = rq;
    @(negedge clk);
    if (goal != 0) begin
      chk({tag, " setup_lat"}, {29'd0, apb.m_sel, apb.m_enable, apb.m_addr == 2'd1}, 32'b101);
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    end
    cyc = 0;
    while (!(|done || |err) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (goal == 0) chk({tag, " zero_lat"}, cyc, 0);
    else chk({tag, " timeout"}, {31'd0, cyc < 500}, 32'd1);
    chk({tag, " done"}, {30'd0, done}, exp_done ? (32'd1 << g) : 32'd0);
    chk({tag, " err"}, {30'd0, err}, exp_done ? 32'd0 : (32'd1 << g));
    req[g] = 1'b0;
    chk({tag, " n_xfer"}, seen.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (base + i < seen.size()) chk($sformatf("%s xfer%0d", tag, i), {21'd0, seen[base + i]}, {21'd0, exp[i]});
    ptr_m = (g + 1) % N_REQ;
    @(negedge clk);
    chk({tag, " post"}, {27'd0, busy, done, err, apb.m_sel}, 32'd0);
  endtask

  initial begin
    req = 2'b11; req_goal = {8'd40, 8'd25};
    repeat (3) @(negedge clk);
    chk("t1 rst_out", {done, err, busy, apb.m_sel, apb.m_enable, apb.m_write, apb.m_addr, apb.m_wdata},
        32'd0);
    reset = 1'b1;
    do_job("t1", 2'b11, 8'd25, 8'd40, 2, -1, 0, 1);
    do_job("t2", 2'b01, 8'd25, 8'd0, 3, -1, 0, 0);
    do_job("t4", 2'b10, 8'd9, 8'd0, 1, -1, 0, 0);
    do_job("t3a", 2'b11, 8'd10, 8'd20, 2, -1, 0, 1);
    do_job("t3b", 2'b11, 8'd10, 8'd20, 1, -1, 0, 1);
    do_job("t3c", 2'b11, 8'd10, 8'd20, 4, -1, 0, 1);
    do_job("t5", 2'b01, 8'd30, 8'd0, 2, 0, 0, 0);
    do_job("t5b", 2'b01, 8'd31, 8'd0, 2, -1, 0, 0);
    do_job("t6", 2'b01, 8'd77, 8'd0, 0, -1, 3, 3);
    do_job("t7", 2'b01, 8'd78, 8'd0, 0, 2 + LIM, 0, 1);
    // mid-job reset: job dropped silently, pointer back to 0
    req = 2'b01; req_goal = {8'd0, 8'd50}; complete_at = 0; err_at = -1;
    repeat (6) @(negedge clk);
    reset = 1'b0; req = 2'b00;
    repeat (2) begin
      @(negedge clk);
      chk("t8 rst_out", {27'd0, busy, done, err, apb.m_sel}, 32'd0);
    end
    reset = 1'b1; ptr_m = 0;
    do_job("t8", 2'b11, 8'd5, 8'd6, 1, -1, 0, 0);
    for (int n = 0; n < 25; n++) begin
      logic [7:0] a, b;
      int ee;
      a  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      ee = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
      do_job($sformatf("r%0d", n), 2'($urandom_range(1, 3)), a, b, $urandom_range(0, 6), ee, 0,
             $urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
